// File: rtl/sram_bus_arbiter_pkg.sv
// rtl/sram_bus_arbiter_pkg.sv - shared constants for the SRAM-like bus arbiter
package sram_bus_arbiter_pkg;

   localparam logic TAG_INST = 1'b0;
   localparam logic TAG_DATA = 1'b1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HOLD_I = 2'd1;
   localparam logic [1:0] ST_HOLD_D = 2'd2;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_bus_arbiter_order_fifo.sv
// rtl/sram_bus_arbiter_order_fifo.sv - in-order tag FIFO recording which port owns each accepted request
module arb_order_fifo #(
   parameter int DEPTH = 2,
   parameter int ID_W  = 1,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              push,
   input  logic [ID_W-1:0]   push_tag,
   input  logic              pop,
   output logic [CNT_W-1:0]  count,
   output logic [ID_W-1:0]   head
);

   logic [ID_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_tag;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - shares one SRAM-like bus between the IF and MEM ports, responses routed in issue order
module sram_bus_arbiter
   import sram_bus_arbiter_pkg::*;
#(
   parameter int MAX_OUTST = 2,
   parameter int ID_W      = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata,
   output logic        arb_err
);

   localparam int CNT_W = $clog2(MAX_OUTST) + 1;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             sel_inst;
   logic             sel_data;
   logic             accept;
   logic             pop;
   logic             fifo_full;
   logic [CNT_W-1:0] fifo_count;
   logic [ID_W-1:0]  fifo_head;
   logic [ID_W-1:0]  push_tag;

   assign fifo_full = (fifo_count == CNT_W'(MAX_OUTST));

   // Data wins in IDLE because it belongs to the older instruction; HOLD locks the choice
   always_comb begin
      sel_inst = 1'b0;
      sel_data = 1'b0;
      case (state)
         ST_HOLD_D: sel_data = 1'b1;
         ST_HOLD_I: sel_inst = 1'b1;
         default: begin
            if (!fifo_full) begin
               if (data_req) begin
                  sel_data = 1'b1;
               end else if (inst_req) begin
                  sel_inst = 1'b1;
               end
            end
         end
      endcase
   end

   assign bus_req   = (sel_data & data_req) | (sel_inst & inst_req);
   assign bus_wr    = sel_data ? data_wr    : inst_wr;
   assign bus_size  = sel_data ? data_size  : inst_size;
   assign bus_addr  = sel_data ? data_addr  : inst_addr;
   assign bus_wstrb = sel_data ? data_wstrb : inst_wstrb;
   assign bus_wdata = sel_data ? data_wdata : inst_wdata;

   assign accept       = bus_req & bus_addr_ok;
   assign inst_addr_ok = accept & sel_inst;
   assign data_addr_ok = accept & sel_data;
   assign push_tag     = sel_data ? ID_W'(TAG_DATA) : ID_W'(TAG_INST);

   always_comb begin
      state_nxt = state;
      if (bus_req && !bus_addr_ok) begin
         state_nxt = sel_data ? ST_HOLD_D : ST_HOLD_I;
      end else begin
         // accepted, or the locked source withdrew its request
         state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= ST_IDLE;
         arb_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (bus_data_ok && fifo_count == '0) begin
            arb_err <= 1'b1;
         end
      end
   end

   assign pop          = bus_data_ok & (fifo_count != '0);
   assign inst_data_ok = pop & (fifo_head == ID_W'(TAG_INST));
   assign data_data_ok = pop & (fifo_head == ID_W'(TAG_DATA));
   assign inst_rdata   = bus_rdata;
   assign data_rdata   = bus_rdata;

   arb_order_fifo #(
      .DEPTH (MAX_OUTST),
      .ID_W  (ID_W)
   ) u_fifo (
      .clk      (clk),
      .resetn   (resetn),
      .push     (accept),
      .push_tag (push_tag),
      .pop      (pop),
      .count    (fifo_count),
      .head     (fifo_head)
   );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - directed self-checking bench for sram_bus_arbiter
module tb_sram_bus_arbiter;
   import sram_bus_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr, inst_wdata;
   logic [3:0]  inst_wstrb;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        bus_req, bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_addr_ok, bus_data_ok;
   logic [31:0] bus_rdata;
   logic        arb_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sram_bus_arbiter #(.MAX_OUTST(2), .ID_W(1)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
      .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
      .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .arb_err(arb_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      inst_req = 1'b0; inst_wr = 1'b0; inst_size = SIZE_WORD; inst_addr = 32'h0;
      inst_wstrb = 4'hF; inst_wdata = 32'h0;
      data_req = 1'b0; data_wr = 1'b0; data_size = SIZE_WORD; data_addr = 32'h0;
      data_wstrb = 4'hF; data_wdata = 32'h0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
   endtask

   initial begin
      resetn = 1'b0;
      idle_inputs();
      tick();
      tick();
      @(negedge clk);
      check("rst_bus_req", 32'(bus_req), 32'd0);
      check("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
      check("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
      check("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
      check("rst_arb_err", 32'(arb_err), 32'd0);
      check("rst_count", 32'(dut.fifo_count), 32'd0);
      check("rst_state", 32'(dut.state), 32'(ST_IDLE));
      tick();
      resetn = 1'b1;

      // single read from IF
      inst_req = 1'b1; inst_addr = 32'h1C00_0000; bus_addr_ok = 1'b1;
      @(negedge clk);
      check("rd_bus_req", 32'(bus_req), 32'd1);
      check("rd_bus_addr", bus_addr, 32'h1C00_0000);
      check("rd_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      check("rd_data_addr_ok", 32'(data_addr_ok), 32'd0);
      tick();
      inst_req = 1'b0; bus_addr_ok = 1'b0;
      @(negedge clk);
      check("rd_count1", 32'(dut.fifo_count), 32'd1);
      tick();
      bus_data_ok = 1'b1; bus_rdata = 32'h0280_0C0C;
      @(negedge clk);
      check("rd_inst_data_ok", 32'(inst_data_ok), 32'd1);
      check("rd_inst_rdata", inst_rdata, 32'h0280_0C0C);
      check("rd_data_data_ok", 32'(data_data_ok), 32'd0);
      tick();
      bus_data_ok = 1'b0;
      @(negedge clk);
      check("rd_count0", 32'(dut.fifo_count), 32'd0);

      // data wins a simultaneous request and stays locked while the bus stalls
      inst_req = 1'b1; inst_addr = 32'h1C00_0100;
      data_req = 1'b1; data_addr = 32'h1C01_0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("pri_bus_addr", bus_addr, 32'h1C01_0000);
         check("pri_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
         if (i > 0) check("pri_state", 32'(dut.state), 32'(ST_HOLD_D));
         tick();
      end
      bus_addr_ok = 1'b1;
      @(negedge clk);
      check("pri_data_addr_ok", 32'(data_addr_ok), 32'd1);
      check("pri_inst_addr_ok2", 32'(inst_addr_ok), 32'd0);
      tick();

      // inst locked; a later data request must not preempt it
      data_req = 1'b0; bus_addr_ok = 1'b0;
      @(negedge clk);
      check("lock_bus_addr0", bus_addr, 32'h1C00_0100);
      tick();
      data_req = 1'b1; data_addr = 32'h1C01_0040;
      @(negedge clk);
      check("lock_state", 32'(dut.state), 32'(ST_HOLD_I));
      check("lock_bus_addr", bus_addr, 32'h1C00_0100);
      tick();
      bus_addr_ok = 1'b1;
      @(negedge clk);
      check("lock_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      check("lock_data_addr_ok", 32'(data_addr_ok), 32'd0);
      tick();

      // FIFO full (data, inst outstanding): no request even though data_req=1
      inst_req = 1'b0;
      @(negedge clk);
      check("full_count", 32'(dut.fifo_count), 32'd2);
      check("full_bus_req", 32'(bus_req), 32'd0);
      check("full_data_addr_ok", 32'(data_addr_ok), 32'd0);
      tick();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hAAAA_0001;
      @(negedge clk);
      check("ord1_bus_req", 32'(bus_req), 32'd0);
      check("ord1_data_data_ok", 32'(data_data_ok), 32'd1);
      check("ord1_data_rdata", data_rdata, 32'hAAAA_0001);
      check("ord1_inst_data_ok", 32'(inst_data_ok), 32'd0);
      tick();

      // count=1: accept data while the inst response pops
      bus_addr_ok = 1'b1; bus_rdata = 32'hBBBB_0002;
      @(negedge clk);
      check("sim_bus_req", 32'(bus_req), 32'd1);
      check("sim_data_addr_ok", 32'(data_addr_ok), 32'd1);
      check("sim_inst_data_ok", 32'(inst_data_ok), 32'd1);
      check("sim_inst_rdata", inst_rdata, 32'hBBBB_0002);
      check("sim_data_data_ok", 32'(data_data_ok), 32'd0);
      tick();
      data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      @(negedge clk);
      check("sim_count", 32'(dut.fifo_count), 32'd1);
      check("sim_head", 32'(dut.fifo_head), 32'(TAG_DATA));
      tick();
      bus_data_ok = 1'b1; bus_rdata = 32'hCCCC_0003;
      @(negedge clk);
      check("drain_data_data_ok", 32'(data_data_ok), 32'd1);
      check("drain_data_rdata", data_rdata, 32'hCCCC_0003);
      tick();

      // response with nothing outstanding
      @(negedge clk);
      check("err_count0", 32'(dut.fifo_count), 32'd0);
      check("err_no_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
      tick();
      bus_data_ok = 1'b0;
      @(negedge clk);
      check("err_set", 32'(arb_err), 32'd1);
      tick();
      inst_req = 1'b1; inst_addr = 32'h1C00_0200; bus_addr_ok = 1'b1;
      @(negedge clk);
      check("err_sticky", 32'(arb_err), 32'd1);
      tick();
      idle_inputs();
      resetn = 1'b0;
      @(negedge clk);
      check("pre_rst_count", 32'(dut.fifo_count), 32'd1);
      tick();
      resetn = 1'b1;
      @(negedge clk);
      check("post_rst_arb_err", 32'(arb_err), 32'd0);
      check("post_rst_count", 32'(dut.fifo_count), 32'd0);
      check("post_rst_state", 32'(dut.state), 32'(ST_IDLE));
      check("post_rst_bus_req", 32'(bus_req), 32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
